// File: rtl/rect_render.sv
// rect_render: scans a clipped, bordered rectangle onto a VGA plot interface with backpressure.
// Optional interior grid lines are enabled with `define RECT_RENDER_GRID_EN (parameter GRID_PITCH).
module rect_render #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int XW = 8,
   parameter int YW = 7,
   parameter int CW = 3
`ifdef RECT_RENDER_GRID_EN
   ,parameter int GRID_PITCH = 6
`endif
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [1:0]    mode,
   input  logic [XW-1:0] rect_x0,
   input  logic [YW-1:0] rect_y0,
   input  logic [XW-1:0] rect_x1,
   input  logic [YW-1:0] rect_y1,
   input  logic [3:0]    border,
   input  logic [CW-1:0] fg_colour,
   input  logic [CW-1:0] in_colour,
   input  logic [CW-1:0] bg_colour,
   input  logic          vga_ready,
   output logic          waitrequest,
   output logic          vga_plot,
   output logic [XW-1:0] vga_x,
   output logic [YW-1:0] vga_y,
   output logic [CW-1:0] vga_colour,
   output logic          done
);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   localparam logic [XW-1:0] XMAX = XW'(SCREEN_W - 1);
   localparam logic [YW-1:0] YMAX = YW'(SCREEN_H - 1);
   state_t        r_state;
   logic [1:0]    r_mode;
   logic [XW-1:0] r_x0, r_x1, r_x;
   logic [YW-1:0] r_y0, r_y1, r_y;
   logic [3:0]    r_b;
   logic [CW-1:0] r_fg, r_in, r_bg;
   logic [XW-1:0] w_x1c, w_xs, w_xe, w_xn;
   logic [YW-1:0] w_y1c, w_ys, w_ye, w_yn;
   logic [XW:0]   w_bx, w_ilx;
   logic [YW:0]   w_by, w_ily;
   logic          w_in, w_int, w_grid, w_skip, w_adv, w_last_x, w_last;
   assign w_x1c = (rect_x1 > XMAX) ? XMAX : rect_x1;
   assign w_y1c = (rect_y1 > YMAX) ? YMAX : rect_y1;
   // Widened bounds so x0+b and x+b never wrap.
   assign w_bx  = (XW+1)'(r_b);
   assign w_by  = (YW+1)'(r_b);
   assign w_ilx = {1'b0, r_x0} + w_bx;
   assign w_ily = {1'b0, r_y0} + w_by;
   assign w_in  = r_x >= r_x0 && r_x <= r_x1 && r_y >= r_y0 && r_y <= r_y1;
   assign w_int = {1'b0, r_x} >= w_ilx && {1'b0, r_x} + w_bx <= {1'b0, r_x1} &&
                  {1'b0, r_y} >= w_ily && {1'b0, r_y} + w_by <= {1'b0, r_y1};
   assign w_xs  = r_mode[0] ? r_x0 : '0;
   assign w_xe  = r_mode[0] ? r_x1 : XMAX;
   assign w_ys  = r_mode[0] ? r_y0 : '0;
   assign w_ye  = r_mode[0] ? r_y1 : YMAX;
   assign w_last_x = r_x == w_xe;
   assign w_last   = w_last_x && r_y == w_ye;
   assign w_xn  = w_last_x ? w_xs : r_x + XW'(1);
   assign w_yn  = r_y + YW'(1);
   assign w_skip = r_mode == 2'b11 && w_int && !w_grid;
   assign w_adv  = r_state == SCAN && (w_skip || vga_ready);
   assign waitrequest = r_state != IDLE;
   assign vga_plot    = r_state == SCAN && !w_skip;
   assign done        = r_state == DONE;
   assign vga_x       = r_x;
   assign vga_y       = r_y;
   assign vga_colour  = (r_mode == 2'b10 || !w_in) ? r_bg : (w_int && !w_grid) ? r_in : r_fg;
`ifdef RECT_RENDER_GRID_EN
   localparam logic [3:0] GLAST = 4'(GRID_PITCH - 1);
   logic [3:0] r_gx, r_gy;
   assign w_grid = w_int && (r_gx == GLAST || r_gy == GLAST);
   // Offsets from the interior corner, restarted whenever the scan reaches x0+b / y0+b.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_gx <= '0;
         r_gy <= '0;
      end else if (r_state == IDLE) begin
         r_gx <= '0;
         r_gy <= '0;
      end else if (w_adv) begin
         r_gx <= ({1'b0, w_xn} == w_ilx || r_gx == GLAST) ? '0 : r_gx + 4'd1;
         if (w_last_x) r_gy <= ({1'b0, w_yn} == w_ily || r_gy == GLAST) ? '0 : r_gy + 4'd1;
      end
`else
   assign w_grid = 1'b0;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state <= IDLE;
         r_mode  <= '0;
         r_x0    <= '0;
         r_x1    <= '0;
         r_y0    <= '0;
         r_y1    <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_b     <= '0;
         r_fg    <= '0;
         r_in    <= '0;
         r_bg    <= '0;
      end else
         case (r_state)
            IDLE: if (start) begin
               r_mode  <= mode;
               r_x0    <= rect_x0;
               r_y0    <= rect_y0;
               r_x1    <= w_x1c;
               r_y1    <= w_y1c;
               r_b     <= border;
               r_fg    <= fg_colour;
               r_in    <= in_colour;
               r_bg    <= bg_colour;
               r_x     <= mode[0] ? rect_x0 : '0;
               r_y     <= mode[0] ? rect_y0 : '0;
               r_state <= (mode[0] && (rect_x0 > w_x1c || rect_y0 > w_y1c)) ? DONE : SCAN;
            end
            SCAN: if (w_adv) begin
               r_x     <= w_xn;
               r_y     <= w_last_x ? w_yn : r_y;
               r_state <= w_last ? DONE : SCAN;
            end
            default: r_state <= IDLE;
         endcase
endmodule

// File: tb/tb_rect_render.sv
// tb_rect_render: randomized and directed checks of rect_render against a pixel-list model.
module tb_rect_render;
  localparam int W = 160, H = 120;
  logic clk = 0, rst = 1, start = 0, vga_ready = 1;
  logic [1:0] mode = 0;
  logic [7:0] rx0 = 0, rx1 = 0;
  logic [6:0] ry0 = 0, ry1 = 0;
  logic [3:0] border = 0;
  logic [2:0] fg = 0, inc = 0, bg = 0;
  logic waitrequest, vga_plot, done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  rect_render dut (.clk(clk), .rst(rst), .start(start), .mode(mode), .rect_x0(rx0), .rect_y0(ry0),
    .rect_x1(rx1), .rect_y1(ry1), .border(border), .fg_colour(fg), .in_colour(inc),
    .bg_colour(bg), .vga_ready(vga_ready), .waitrequest(waitrequest), .vga_plot(vga_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .done(done));
  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int pix(input int m, x, y, x0, y0, x1, y1, b, f, i, g, output bit plot);
    bit inr, intr, grd;
    inr  = x >= x0 && x <= x1 && y >= y0 && y <= y1;
    intr = x >= x0 + b && x <= x1 - b && y >= y0 + b && y <= y1 - b;
    grd  = 0;
`ifdef RECT_RENDER_GRID_EN
    grd = intr && (((x - x0 - b) % 6) == 5 || ((y - y0 - b) % 6) == 5);
`endif
    plot = !(m == 3 && intr && !grd);
    if (m == 2 || !inr) return g;
    return (intr && !grd) ? i : f;
  endfunction
  task automatic run(input int m, x0, y0, x1, y1, b, f, i, g, rdy,
                     output int plots, output int fgs, output int dcyc);
    int x1c, y1c, xs, xe, ys, ye, scanned, c, cur, stall;
    int q[$];
    bit p;
    x1c = x1 > W - 1 ? W - 1 : x1;
    y1c = y1 > H - 1 ? H - 1 : y1;
    xs = m % 2 ? x0 : 0;
    xe = m % 2 ? x1c : W - 1;
    ys = m % 2 ? y0 : 0;
    ye = m % 2 ? y1c : H - 1;
    scanned = 0;
    for (int y = ys; y <= ye; y++)
      for (int x = xs; x <= xe; x++) begin
        scanned++;
        c = pix(m, x, y, x0, y0, x1c, y1c, b, f, i, g, p);
        if (p) q.push_back((x << 16) | (y << 8) | c);
      end
    if (ys > ye) scanned = 0;
    mode = 2'(m); rx0 = 8'(x0); ry0 = 7'(y0); rx1 = 8'(x1); ry1 = 7'(y1);
    border = 4'(b); fg = 3'(f); inc = 3'(i); bg = 3'(g);
    start = 1;
    @(negedge clk);
    start = 0;
    mode = 2'($urandom); rx0 = 8'($urandom); border = 4'($urandom);
    plots = 0; fgs = 0; dcyc = -1; stall = -1;
    for (int k = 0; k < scanned * 20 + 20; k++) begin
      vga_ready = rdy == 0 ? 1'b1 : rdy == 1 ? (k % 4 == 0 || k % 4 == 3) : 1'($urandom_range(0, 1));
      if (done) begin
        dcyc = k + 1;
        break;
      end
      cur = vga_plot ? ((int'(vga_x) << 16) | (int'(vga_y) << 8) | int'(vga_colour)) : -2;
      if (stall >= 0) chk("stall_hold", cur, stall);
      stall = -1;
      if (vga_plot && vga_ready) begin
        plots++;
        if (int'(vga_colour) == f) fgs++;
        chk("pixel", cur, q.size() > 0 ? q.pop_front() : -1);
      end else if (vga_plot) stall = cur;
      @(negedge clk);
    end
    vga_ready = 1;
    chk("done_seen", dcyc > 0, 1);
    chk("pixels_left", q.size(), 0);
    if (rdy == 0) chk("latency", dcyc, scanned + 1);
    chk("done_wr_plot", {waitrequest, vga_plot}, 2'b10);
    @(negedge clk);
    chk("idle_after_done", {waitrequest, done}, 0);
  endtask
  initial begin
    int plots, fgs, dcyc, cnt, x0, y0;
    #2;
    chk("reset_outputs", {waitrequest, vga_plot, done, vga_x, vga_y, vga_colour}, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    run(0, 26, 6, 133, 113, 6, 7, 0, 0, 0, plots, fgs, dcyc);
    chk("frame_plots", plots, 19200);
    chk("frame_white", fgs, 2448);
    chk("frame_done_cyc", dcyc, 19201);
    run(1, 26, 6, 133, 113, 6, 7, 0, 0, 0, plots, fgs, dcyc);
    chk("fill_plots", plots, 11664);
    run(3, 26, 6, 133, 113, 6, 7, 0, 0, 0, plots, fgs, dcyc);
    chk("outline_plots", plots, 2448);
    chk("outline_done_cyc", dcyc, 11665);
    run(1, 0, 0, 3, 1, 1, 5, 2, 0, 1, plots, fgs, dcyc);
    chk("bp_plots", plots, 8);
    run(1, 50, 10, 40, 20, 1, 5, 2, 0, 0, plots, fgs, dcyc);
    chk("empty_plots", plots, 0);
    chk("empty_done_cyc", dcyc, 1);
    run(1, 150, 100, 255, 127, 2, 5, 2, 1, 2, plots, fgs, dcyc);
    chk("clip_plots", plots, 200);
    run(1, 10, 10, 29, 19, 0, 7, 2, 1, 0, plots, fgs, dcyc);
    chk("noborder_fg", fgs, 0);
    for (int t = 0; t < 8; t++) begin
      x0 = $urandom_range(0, 159);
      y0 = $urandom_range(0, 119);
      run($urandom_range(0, 1) ? 3 : 1, x0, y0, x0 + $urandom_range(0, 24) - 2,
          y0 + $urandom_range(0, 8), $urandom_range(0, 4), $urandom_range(0, 7),
          $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 2), plots, fgs, dcyc);
    end
`ifdef RECT_RENDER_GRID_EN
    run(1, 0, 0, 13, 13, 1, 7, 1, 0, 0, plots, fgs, dcyc);
    chk("grid_fg", fgs, 96);
`endif
    mode = 0; rx0 = 26; ry0 = 6; rx1 = 133; ry1 = 113; border = 6; fg = 7; inc = 0; bg = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    cnt = 0;
    for (int k = 0; k < 1000 && cnt < 500; k++) begin
      if (vga_plot) cnt++;
      if (cnt < 500) @(negedge clk);
    end
    chk("reset_reach_500", cnt, 500);
    #2 rst = 1;
    #1 chk("async_reset", {waitrequest, vga_plot, done}, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    run(2, 26, 6, 133, 113, 6, 7, 5, 2, 0, plots, fgs, dcyc);
    chk("clear_plots", plots, 19200);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/rect_render.md
Name: rect_render

Overview:
- Parametrised successor to the fixed-square screen initialiser.
- Scans pixels and drives the VGA plot interface (vga_plot/vga_x/vga_y/vga_colour) to draw one axis-aligned rectangle, with run-time position, size, border thickness, three colours and four scan modes.
- Supports plot backpressure (vga_ready).
- Used for the playfield frame, the screen clear, and redrawing HUD boxes in the snake game.

Parameters:
- SCREEN_W, 160, screen width in pixels.
- SCREEN_H, 120, screen height in pixels.
- XW, 8, x coordinate width (must satisfy 2^XW >= SCREEN_W).
- YW, 7, y coordinate width (must satisfy 2^YW >= SCREEN_H).
- CW, 3, colour width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  request; sampled only in IDLE
- mode  in  2  00 full-screen, 01 box fill, 10 clear, 11 outline only
- rect_x0  in  XW  left edge, inclusive
- rect_y0  in  YW  top edge, inclusive
- rect_x1  in  XW  right edge, inclusive
- rect_y1  in  YW  bottom edge, inclusive
- border  in  4  border thickness in pixels, 0..15
- fg_colour  in  CW  border colour
- in_colour  in  CW  interior colour
- bg_colour  in  CW  colour outside the rectangle
- vga_ready  in  1  sink accepts the current plot
- waitrequest  out  1  high while busy
- vga_plot  out  1  current pixel valid
- vga_x  out  XW  pixel x
- vga_y  out  YW  pixel y
- vga_colour  out  CW  pixel colour
- done  out  1  one-cycle pulse on completion

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE immediately.
  - All outputs are 0.
  - An operation in progress is abandoned; there is no resume.
- IDLE:
  - waitrequest=0, vga_plot=0.
  - start=1 at a clock edge latches all inputs. The latched copies are used until done; later input changes are ignored.
  - Next state is SCAN.
- Clipping:
  - rect_x1 is clipped to SCREEN_W-1 and rect_y1 to SCREEN_H-1.
  - If x0>x1 or y0>y1 after clipping, the rectangle is empty.
- Pixel classification (computed from latched values):
  - "in rect": x0<=x<=x1 and y0<=y<=y1.
  - "interior": x0+b<=x<=x1-b and y0+b<=y<=y1-b. Use XW+1/YW+1-bit arithmetic; no wrap.
  - "border": in rect and not interior. border=0 means no border pixels.
- Scan region:
  - Modes 00 and 10: the whole screen, (0,0)..(SCREEN_W-1,SCREEN_H-1).
  - Modes 01 and 11: the clipped rectangle only.
  - Order is row-major: x increments fastest; y increments when x wraps.
- Colour:
  - Border pixels: fg_colour.
  - Interior pixels: in_colour.
  - Outside the rectangle: bg_colour.
  - Mode 10: every pixel is bg_colour.
- SCAN:
  - waitrequest=1.
  - The first pixel is presented the cycle after start is sampled.
  - vga_plot=1 with x/y/colour held stable until vga_ready=1. The pixel advances on the edge where vga_plot and vga_ready are both 1.
  - Mode 11, interior pixels: vga_plot=0 for one cycle, then advance. The skip costs one cycle and does not depend on vga_ready.
  - When the last pixel is accepted or skipped, the next state is DONE.
- DONE:
  - Lasts exactly one cycle: done=1, waitrequest=1, vga_plot=0.
  - Next state is IDLE.
- Empty rectangle in modes 01 or 11: SCAN is skipped and DONE follows start directly.
- start while busy is ignored. start held high re-triggers on the first IDLE cycle.
- Latency with vga_ready=1: busy cycles = scanned pixels + 1.

Optional Feature:
- Macro: RECT_RENDER_GRID_EN, with parameter GRID_PITCH, default 6, range 2..15.
- Defined:
  - Interior pixels get fg_colour where (x-(x0+b)) mod GRID_PITCH == GRID_PITCH-1 or (y-(y0+b)) mod GRID_PITCH == GRID_PITCH-1.
  - Generated with per-axis counters that reset at each row/column start. No divider.
  - Mode 11 plots grid pixels and skips non-grid interior pixels.
- Undefined: no grid; the GRID_PITCH parameter is absent; behaviour is as above.

Test Plan:
- Frame, mode 00: rect (26,6)-(133,113), border=6, fg=111, in=000, bg=000, vga_ready=1.
  - 19200 plots.
  - White exactly where in (26..133,6..113) but not in (32..127,12..107); black elsewhere.
  - done pulse in cycle 19201 after start; waitrequest=0 the next cycle.
- Box fill, mode 01: same rect.
  - 11664 plots.
  - First pixel (26,6), last pixel (133,113).
  - Mode 11 on the same rect: 2448 plots, done 11665 cycles after start.
- Backpressure: mode 01, rect (0,0)-(3,1), vga_ready toggling 1,0,0,1, ...
  - Exactly 8 accepted plots in row-major order.
  - Coordinates and colour stable during every stall.
  - done only after the 8th acceptance.
- Edge cases:
  - rect_x0=50, rect_x1=40, mode 01: zero plots, done the cycle after start.
  - rect (150,100)-(255,127): clipped to (150,100)-(159,119), 200 plots.
  - border=0: no fg pixels.
- Reset mid-operation: rst=1 at pixel 500 of mode 00.
  - waitrequest, vga_plot and done go to 0 without waiting for a clock.
  - After release, a new start with mode 10 and bg=010 plots 19200 pixels of colour 010.
- Grid, with RECT_RENDER_GRID_EN and GRID_PITCH=6: rect (0,0)-(13,13), border=1, mode 01.
  - Interior pixels at interior-relative x=5 or y=5 are fg; all other interior pixels are in_colour.
